inst_fetch_queue: RTL and testbench

- Instruction fetch front end that sits directly upstream of the pipeline IF latch. It feeds the IF latch one 32-bit instruction per handshake.
- Reads the byte-wide instruction RAM (512 x 8), one byte per cycle. Assembles each instruction little-endian as {b3,b2,b1,b0}.
- Buffers completed words, with their PC, in a small prefetch queue.
- Flushes the queue and restarts fetch on a branch or jump redirect from the MEM stage.

---
 rtl/cpu_pkg.sv | 11 +
 rtl/ifq_fifo.sv | 49 ++++
 rtl/inst_fetch_queue.sv | 123 ++++++++++++
 tb/tb_inst_fetch_queue.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants, queue entry type and fetch FSM states for the instruction fetch front end
package cpu_pkg;
    localparam int INST_ADDR_W = 9;
    localparam int WORD_BYTES = 4;
    localparam logic [31:0] NOP_WORD = 32'h0;
    typedef struct packed {
        logic [INST_ADDR_W-1:0] pc;
        logic [31:0] inst;
    } ifq_entry_t;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} ifq_state_t;
endpackage

// File: rtl/ifq_fifo.sv
// ifq_fifo: synchronous DEPTH-entry FIFO of {pc, inst} entries with flush
// Ports: clka/reset (sync, active-high); push/wdata enqueue; pop dequeues head;
//        flush empties the queue and wins over push/pop; rdata is the head entry;
//        count/full/empty report occupancy.
module ifq_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic                   clka,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  ifq_entry_t             wdata,
    output ifq_entry_t             rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PW = $clog2(DEPTH);
    ifq_entry_t mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0] count_q, count_d;
    logic do_push, do_pop;
    assign count = count_q;
    assign full = count_q == (PW+1)'(DEPTH);
    assign empty = count_q == '0;
    assign rdata = mem_q[rd_ptr_q];
    always_comb begin
        do_push = push && !full && !flush;
        do_pop = pop && !empty && !flush;
        wr_ptr_d = flush ? '0 : wr_ptr_q + PW'(do_push);
        rd_ptr_d = flush ? '0 : rd_ptr_q + PW'(do_pop);
        count_d = flush ? '0 : count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
    always_ff @(posedge clka) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q <= count_d;
        end
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end
endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: byte-serial instruction fetch with prefetch queue feeding the IF latch
// Ports: clka/reset (sync, active-high); mem_en/mem_addr/mem_rdata byte RAM port
//        (data one cycle after request); redirect_valid/redirect_pc flush and restart;
//        inst_valid/inst_ready/inst_out/inst_pc head handshake; q_count occupancy.
// Option: IFQ_NOP_SQUASH_EN drops all-zero words instead of queueing them.
module inst_fetch_queue
    import cpu_pkg::*;
#(
    parameter int ADDR_W = INST_ADDR_W,
    parameter int DEPTH = 4,
    parameter int RESET_PC = 0
)(
    input  logic                   clka,
    input  logic                   reset,
    output logic                   mem_en,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic [7:0]             mem_rdata,
    input  logic                   redirect_valid,
    input  logic [ADDR_W-1:0]      redirect_pc,
    output logic                   inst_valid,
    input  logic                   inst_ready,
    output logic [31:0]            inst_out,
    output logic [ADDR_W-1:0]      inst_pc,
    output logic [$clog2(DEPTH):0] q_count
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W-1:0] PC_MASK = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC) & PC_MASK;
    ifq_state_t state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, rd_pc_q, rd_pc_d, mem_addr_q, mem_addr_d;
    logic [1:0] byte_idx_q, byte_idx_d, rd_slot_q, rd_slot_d;
    logic [CW-1:0] res_q, res_d, count;
    logic [CW:0] count_sum;
    logic [23:0] asm_q, asm_d;
    logic rd_valid_q, rd_valid_d, mem_en_q, mem_en_d;
    logic room, start, done, push, full, empty;
    logic [31:0] word;
    ifq_entry_t wentry, head;
    ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clka(clka), .reset(reset), .push(push), .pop(inst_valid && inst_ready),
        .flush(redirect_valid), .wdata(wentry), .rdata(head), .count(count),
        .full(full), .empty(empty)
    );
    assign mem_en = mem_en_q;
    assign mem_addr = mem_addr_q;
    assign inst_valid = !empty;
    assign inst_out = empty ? 32'h0 : head.inst;
    assign inst_pc = empty ? '0 : ADDR_W'(head.pc);
    assign q_count = count;
    always_comb begin
        // res_q counts words started but not yet pushed, so a started word always owns a slot
        count_sum = {1'b0, count} + {1'b0, res_q};
        room = !full && count_sum < (CW+1)'(DEPTH);
        done = rd_valid_q && rd_slot_q == 2'd3;
        word = {mem_rdata, asm_q};
`ifdef IFQ_NOP_SQUASH_EN
        push = done && word != NOP_WORD;
`else
        push = done;
`endif
        wentry.pc = INST_ADDR_W'(rd_pc_q);
        wentry.inst = word;
        asm_d = asm_q;
        if (rd_valid_q && rd_slot_q == 2'd0) asm_d[7:0] = mem_rdata;
        if (rd_valid_q && rd_slot_q == 2'd1) asm_d[15:8] = mem_rdata;
        if (rd_valid_q && rd_slot_q == 2'd2) asm_d[23:16] = mem_rdata;
        state_d = state_q;
        fetch_pc_d = fetch_pc_q;
        byte_idx_d = byte_idx_q;
        start = 1'b0;
        if (state_q == IDLE) begin
            start = room;
            state_d = room ? ISSUE : IDLE;
        end else if (state_q == ISSUE) begin
            byte_idx_d = byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
                fetch_pc_d = fetch_pc_q + ADDR_W'(WORD_BYTES);
                start = room;
                state_d = room ? ISSUE : DRAIN;
            end
        end else begin
            state_d = IDLE;
        end
        res_d = res_q + CW'(start) - CW'(done);
        // a byte requested in a redirect cycle belongs to the old stream and is dropped
        rd_valid_d = mem_en_q && !redirect_valid;
        rd_slot_d = byte_idx_q;
        rd_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            state_d = ISSUE;
            fetch_pc_d = redirect_pc & PC_MASK;
            byte_idx_d = 2'd0;
            res_d = CW'(1);
        end
        mem_en_d = state_d == ISSUE;
        mem_addr_d = fetch_pc_d + ADDR_W'(byte_idx_d);
    end
    always_ff @(posedge clka) begin
        if (reset) begin
            state_q <= IDLE;
            fetch_pc_q <= RST_PC;
            byte_idx_q <= 2'd0;
            res_q <= '0;
            rd_valid_q <= 1'b0;
            rd_slot_q <= 2'd0;
            rd_pc_q <= '0;
            asm_q <= '0;
            mem_en_q <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q <= state_d;
            fetch_pc_q <= fetch_pc_d;
            byte_idx_q <= byte_idx_d;
            res_q <= res_d;
            rd_valid_q <= rd_valid_d;
            rd_slot_q <= rd_slot_d;
            rd_pc_q <= rd_pc_d;
            asm_q <= asm_d;
            mem_en_q <= mem_en_d;
            mem_addr_q <= mem_addr_d;
        end
    end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: directed self-checking bench for inst_fetch_queue
module tb_inst_fetch_queue;
    logic clka = 1'b0;
    logic reset = 1'b1;
    logic mem_en;
    logic [8:0] mem_addr;
    logic [7:0] mem_rdata = 8'h0;
    logic redirect_valid = 1'b0;
    logic [8:0] redirect_pc = 9'h0;
    logic inst_valid;
    logic inst_ready = 1'b0;
    logic [31:0] inst_out;
    logic [8:0] inst_pc;
    logic [2:0] q_count;
    logic [7:0] ram [512];
    int n_cmp = 0;
    int n_bad = 0;
    logic [8:0] addr_log [$];
    logic [8:0] got_pc [$];
    logic [31:0] got_inst [$];

    inst_fetch_queue #(.ADDR_W(9), .DEPTH(4), .RESET_PC(0)) dut (
        .clka(clka), .reset(reset), .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_out(inst_out),
        .inst_pc(inst_pc), .q_count(q_count)
    );

    always #5 clka = ~clka;

    always @(posedge clka) if (mem_en) mem_rdata <= ram[mem_addr];

    always @(negedge clka) begin
        if (!reset) begin
            if (mem_en) addr_log.push_back(mem_addr);
            if (inst_valid && inst_ready && !redirect_valid) begin
                got_pc.push_back(inst_pc);
                got_inst.push_back(inst_out);
            end
            n_cmp++;
            assert (q_count <= 3'd4) else begin
                n_bad++;
                $error("FAIL q_overflow: observed %0d required <= 4", q_count);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] word_at(input logic [8:0] a);
        return {ram[a + 9'd3], ram[a + 9'd2], ram[a + 9'd1], ram[a]};
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clka);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic redir(input logic [8:0] pc, input logic rdy);
        redirect_valid = 1'b1;
        redirect_pc = pc;
        inst_ready = rdy;
        cyc(1);
        redirect_valid = 1'b0;
        addr_log.delete();
        got_pc.delete();
        got_inst.delete();
    endtask

    task automatic stale_test(input string tag, input logic [8:0] hit);
        int k;
        redir(9'h080, 1'b0);
        for (k = 0; k < 40 && !(mem_en && mem_addr == hit); k++) cyc(1);
        chk({tag, "_sync"}, 32'(k < 40), 32'd1);
        redir(9'h0A1, 1'b1);
        chk({tag, "_count"}, q_count, 0);
        cyc(10);
        chk({tag, "_pc"}, got_pc[0], 9'h0A0);
        chk({tag, "_inst"}, got_inst[0], word_at(9'h0A0));
    endtask

    initial begin
        int k;
        for (int i = 0; i < 512; i++) ram[i] = 8'(i * 37 + 11);
        ram[0] = 8'h20;
        ram[1] = 8'h08;
        ram[2] = 8'h22;
        ram[3] = 8'h00;
        for (int i = 0; i < 4; i++) ram[9'h104 + i] = 8'h00;
        // reset and first-word latency
        inst_ready = 1'b1;
        cyc(2);
        reset = 1'b0;
        chk("rst_mem_en", mem_en, 0);
        chk("rst_valid", inst_valid, 0);
        chk("rst_inst", inst_out, 0);
        chk("rst_pc", inst_pc, 0);
        chk("rst_count", q_count, 0);
        addr_log.delete();
        cyc(1);
        chk("first_en", mem_en, 1);
        chk("first_addr", mem_addr, 0);
        cyc(4);
        chk("lat_c5_valid", inst_valid, 0);
        cyc(1);
        chk("lat_c6_valid", inst_valid, 1);
        chk("lat_inst", inst_out, 32'h00220820);
        chk("lat_pc", inst_pc, 0);
        for (int i = 0; i < 5; i++) chk("t1_addr", addr_log[i], 32'(i));
        // fill the queue with the IF latch stalled
        redir(9'h000, 1'b0);
        cyc(30);
        addr_log.delete();
        cyc(10);
        chk("full_count", q_count, 4);
        chk("full_no_fetch", addr_log.size(), 0);
        chk("full_en", mem_en, 0);
        chk("full_valid", inst_valid, 1);
        inst_ready = 1'b1;
        got_pc.delete();
        got_inst.delete();
        cyc(6);
        for (int i = 0; i < 4; i++) begin
            chk("full_pc", got_pc[i], 32'(i * 4));
            chk("full_inst", got_inst[i], word_at(9'(i * 4)));
        end
        // redirect with three words queued
        redir(9'h040, 1'b0);
        for (k = 0; k < 60 && q_count != 3'd3; k++) cyc(1);
        chk("q3_reached", q_count, 3);
        redir(9'h031, 1'b1);
        chk("rd_valid", inst_valid, 0);
        chk("rd_count", q_count, 0);
        chk("rd_en", mem_en, 1);
        chk("rd_addr", mem_addr, 9'h030);
        cyc(10);
        for (int i = 0; i < 4; i++) chk("rd_seq", addr_log[i], 32'(9'h030 + i));
        chk("rd_first_pc", got_pc[0], 9'h030);
        chk("rd_first_inst", got_inst[0], word_at(9'h030));
        // redirect with stale bytes in flight
        stale_test("stale_b2", 9'h082);
        stale_test("stale_b3", 9'h083);
        // PC wrap-around
        redir(9'h1FC, 1'b1);
        cyc(12);
        chk("wrap_a0", addr_log[0], 9'h1FC);
        chk("wrap_a1", addr_log[1], 9'h1FD);
        chk("wrap_a2", addr_log[2], 9'h1FE);
        chk("wrap_a3", addr_log[3], 9'h1FF);
        chk("wrap_a4", addr_log[4], 9'h000);
        chk("wrap_pc0", got_pc[0], 9'h1FC);
        chk("wrap_inst0", got_inst[0], word_at(9'h1FC));
        chk("wrap_pc1", got_pc[1], 9'h000);
        chk("wrap_inst1", got_inst[1], 32'h00220820);
        // zero-word handling
        redir(9'h100, 1'b1);
        cyc(16);
        chk("nop_pc0", got_pc[0], 9'h100);
        chk("nop_inst0", got_inst[0], word_at(9'h100));
`ifdef IFQ_NOP_SQUASH_EN
        chk("nop_pc1", got_pc[1], 9'h108);
        chk("nop_inst1", got_inst[1], word_at(9'h108));
`else
        chk("nop_pc1", got_pc[1], 9'h104);
        chk("nop_inst1", got_inst[1], 32'h0);
        chk("nop_pc2", got_pc[2], 9'h108);
        chk("nop_inst2", got_inst[2], word_at(9'h108));
`endif
        // reset mid-word beats a simultaneous redirect
        inst_ready = 1'b0;
        cyc(3);
        reset = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 9'h1F0;
        cyc(1);
        reset = 1'b0;
        redirect_valid = 1'b0;
        chk("rstpri_en", mem_en, 0);
        chk("rstpri_count", q_count, 0);
        chk("rstpri_valid", inst_valid, 0);
        cyc(1);
        chk("rstpri_en2", mem_en, 1);
        chk("rstpri_addr", mem_addr, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
